// File: rtl/membus_rr_arbiter.sv
// ----------------------------------------------------------------------------
// membus_rr_arbiter
//
// Two-master round-robin arbiter for the native valid/ready memory bus. It
// shares one slave (the data RAM) between the CPU (m0) and the UART-driven
// loader/DMA master (m1), granting one complete transaction at a time.
// A watchdog completes any transaction that waits too long for s_ready with
// an error response, so neither master can hang the bus.
//
// Parameters
//   TIMEOUT   max cycles a granted transaction may wait for s_ready
//             (1..2**TO_W-1; 0 is illegal). The error response is returned
//             in the TIMEOUT-th BUSY cycle without s_ready.
//   TO_W      width of the timeout counter
//   ERR_DATA  read data returned to the master on a timeout
//
// Ports
//   clk                  system clock, all logic on posedge
//   rst                  synchronous reset, active-high
//   m0_valid/addr/wdata/wstrb   master 0 (CPU) request, held until m0_ready
//   m0_ready/rdata/err   master 0 completion pulse, read data, timeout flag
//   m1_*                 identical set for master 1 (loader/DMA)
//   s_valid/addr/wdata/wstrb    slave request (combinational from grant)
//   s_ready/rdata        slave completion and read data
//   gnt                  one-hot current owner {m1,m0}, 00 when idle
//   to_sticky            set by any timeout, cleared only by rst
// ----------------------------------------------------------------------------
module membus_rr_arbiter #(
  parameter int unsigned TIMEOUT  = 255,
  parameter int unsigned TO_W     = 8,
  parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_err,

  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_err,

  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,

  output logic [1:0]  gnt,
  output logic        to_sticky
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  // The counter holds the number of BUSY cycles already spent waiting, so the
  // watchdog fires in the cycle where that count is about to reach TIMEOUT.
  localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic            last_q, last_d;      // 1 = m1 won the last tie
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            sticky_q, sticky_d;

  logic            sel_valid;           // valid of the granted master
  logic            done;                // completion pulse to the owner
  logic            done_err;
  logic [31:0]     done_rdata;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      gnt_q    <= 2'b00;
      last_q   <= 1'b1;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    s_valid    = 1'b0;
    s_addr     = '0;
    s_wdata    = '0;
    s_wstrb    = '0;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    sel_valid  = gnt_q[1] ? m1_valid : m0_valid;

    // Request fields follow the owner; gnt is 00 outside BUSY so they idle at 0.
    if (gnt_q[0]) begin
      s_addr  = m0_addr;
      s_wdata = m0_wdata;
      s_wstrb = m0_wstrb;
    end else if (gnt_q[1]) begin
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wstrb = m1_wstrb;
    end

    unique case (state_q)
      IDLE: begin
        if (m0_valid && m1_valid) begin
          // Tie: the master that did not win the previous tie goes next.
          if (last_q) begin
            gnt_d  = 2'b01;
            last_d = 1'b0;
          end else begin
            gnt_d  = 2'b10;
            last_d = 1'b1;
          end
          state_d = BUSY;
        end else if (m0_valid) begin
          gnt_d   = 2'b01;
          state_d = BUSY;
        end else if (m1_valid) begin
          gnt_d   = 2'b10;
          state_d = BUSY;
        end
      end

      BUSY: begin
        if (!sel_valid) begin
          // Owner withdrew its request: abandon silently, no ready pulse.
          gnt_d   = 2'b00;
          cnt_d   = '0;
          state_d = RELEASE;
        end else begin
          s_valid = 1'b1;
          if (s_ready) begin
            // Slave completion has priority over a coinciding timeout.
            done       = 1'b1;
            done_rdata = s_rdata;
            gnt_d      = 2'b00;
            cnt_d      = '0;
            state_d    = RELEASE;
          end else if (cnt_q == TO_LAST) begin
            done       = 1'b1;
            done_err   = 1'b1;
            done_rdata = ERR_DATA;
            sticky_d   = 1'b1;
            gnt_d      = 2'b00;
            cnt_d      = '0;
            state_d    = RELEASE;
          end else if (cnt_q != TO_MAX) begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
      end

      RELEASE: begin
        // One dead cycle so an owner still holding valid is not re-granted.
        gnt_d   = 2'b00;
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        gnt_d   = 2'b00;
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // A reset cycle aborts the transaction: no completion reaches a master.
    if (rst) begin
      done     = 1'b0;
      sticky_d = sticky_q;
    end
  end

  assign m0_ready  = done & gnt_q[0];
  assign m0_err    = done & done_err & gnt_q[0];
  assign m0_rdata  = (done & gnt_q[0]) ? done_rdata : 32'h0;
  assign m1_ready  = done & gnt_q[1];
  assign m1_err    = done & done_err & gnt_q[1];
  assign m1_rdata  = (done & gnt_q[1]) ? done_rdata : 32'h0;
  assign gnt       = gnt_q;
  assign to_sticky = sticky_q;

endmodule

// File: tb/tb_membus_rr_arbiter.sv
// ----------------------------------------------------------------------------
// tb_membus_rr_arbiter
//
// Directed bench for membus_rr_arbiter with TIMEOUT=8. Inputs change 1 ns
// after a rising edge and outputs are compared right after that (or 1 ns
// after a same-cycle input change), well away from the next edge.
// ----------------------------------------------------------------------------
module tb_membus_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m0_err, m1_ready, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  gnt;
  logic        to_sticky;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  membus_rr_arbiter #(
    .TIMEOUT (8),
    .TO_W    (8),
    .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_valid (m0_valid),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_wstrb (m0_wstrb),
    .m0_ready (m0_ready),
    .m0_rdata (m0_rdata),
    .m0_err   (m0_err),
    .m1_valid (m1_valid),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_wstrb (m1_wstrb),
    .m1_ready (m1_ready),
    .m1_rdata (m1_rdata),
    .m1_err   (m1_err),
    .s_valid  (s_valid),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wstrb  (s_wstrb),
    .s_ready  (s_ready),
    .s_rdata  (s_rdata),
    .gnt      (gnt),
    .to_sticky(to_sticky)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Advance one clock; return 1 ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();

    // ---------------- reset state ----------------
    do_reset();
    check("rst_gnt",    32'(gnt),       32'h0);
    check("rst_svalid", 32'(s_valid),   32'h0);
    check("rst_m0rdy",  32'(m0_ready),  32'h0);
    check("rst_m1rdy",  32'(m1_ready),  32'h0);
    check("rst_sticky", 32'(to_sticky), 32'h0);

    // ---------------- 1: m0 read, slave ready on 3rd BUSY cycle ----------------
    m0_valid = 1'b1; m0_addr = 32'h0004_0010; m0_wstrb = 4'h0;
    step();                                   // BUSY cycle 1
    check("t1_gnt",    32'(gnt),      32'h1);
    check("t1_svalid", 32'(s_valid),  32'h1);
    check("t1_saddr",  s_addr,        32'h0004_0010);
    check("t1_swstrb", 32'(s_wstrb),  32'h0);
    check("t1_rdy_c1", 32'(m0_ready), 32'h0);
    step();                                   // BUSY cycle 2
    check("t1_rdy_c2", 32'(m0_ready), 32'h0);
    step();                                   // BUSY cycle 3
    s_ready = 1'b1; s_rdata = 32'h1234_5678;
    #1;
    check("t1_rdy",    32'(m0_ready), 32'h1);
    check("t1_rdata",  m0_rdata,      32'h1234_5678);
    check("t1_err",    32'(m0_err),   32'h0);
    check("t1_m1rdy",  32'(m1_ready), 32'h0);
    check("t1_m1rd",   m1_rdata,      32'h0);
    step();                                   // RELEASE
    m0_valid = 1'b0; s_ready = 1'b0; s_rdata = '0;
    #1;
    check("t1_rel_gnt", 32'(gnt),      32'h0);
    check("t1_rel_rdy", 32'(m0_ready), 32'h0);
    check("t1_rel_sv",  32'(s_valid),  32'h0);
    step();                                   // IDLE
    check("t1_idle_gnt", 32'(gnt),     32'h0);

    // ---------------- 2: both masters continuous, 0-wait slave ----------------
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0100;
    m1_valid = 1'b1; m1_addr = 32'h0000_0200;
    s_ready  = 1'b1; s_rdata = 32'h5555_AAAA;
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  exp_gnt;
      logic [31:0] exp_addr;
      exp_gnt  = (i % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr = (i % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200;
      step();                                 // BUSY: completes at once
      check($sformatf("t2_gnt%0d", i),   32'(gnt),      32'(exp_gnt));
      check($sformatf("t2_addr%0d", i),  s_addr,        exp_addr);
      check($sformatf("t2_m0rdy%0d", i), 32'(m0_ready), 32'(exp_gnt[0]));
      check($sformatf("t2_m1rdy%0d", i), 32'(m1_ready), 32'(exp_gnt[1]));
      step();                                 // RELEASE
      check($sformatf("t2_rel%0d", i),   32'(gnt),      32'h0);
      step();                                 // IDLE, decision made at this edge
      check($sformatf("t2_idl%0d", i),   32'(s_valid),  32'h0);
    end

    // ---------------- 3: m1 write, slave never ready -> timeout ----------------
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h0000_0080; m1_wdata = 32'hCAFE_F00D; m1_wstrb = 4'hF;
    step();                                   // BUSY cycle 1
    check("t3_gnt",    32'(gnt),     32'h2);
    check("t3_swdata", s_wdata,      32'hCAFE_F00D);
    check("t3_swstrb", 32'(s_wstrb), 32'hF);
    for (int k = 1; k <= 7; k++) begin
      check($sformatf("t3_wait%0d", k), 32'(m1_ready), 32'h0);
      step();
    end
    // BUSY cycle 8
    check("t3_rdy",     32'(m1_ready),  32'h1);
    check("t3_err",     32'(m1_err),    32'h1);
    check("t3_rdata",   m1_rdata,       32'hDEAD_BEEF);
    check("t3_svalid",  32'(s_valid),   32'h1);
    check("t3_m0rdy",   32'(m0_ready),  32'h0);
    step();                                   // RELEASE
    m1_valid = 1'b0;
    #1;
    check("t3_sticky",  32'(to_sticky), 32'h1);
    check("t3_rel_rdy", 32'(m1_ready),  32'h0);
    check("t3_rel_gnt", 32'(gnt),       32'h0);

    // ---------------- 4: s_ready on the timeout cycle ----------------
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0044;
    step();                                   // BUSY cycle 1
    for (int k = 1; k <= 7; k++) step();      // reach BUSY cycle 8
    s_ready = 1'b1; s_rdata = 32'h0BAD_F00D;
    #1;
    check("t4_rdy",    32'(m0_ready),  32'h1);
    check("t4_err",    32'(m0_err),    32'h0);
    check("t4_rdata",  m0_rdata,       32'h0BAD_F00D);
    step();
    m0_valid = 1'b0; s_ready = 1'b0;
    #1;
    check("t4_sticky", 32'(to_sticky), 32'h0);

    // ---------------- 5: reset while BUSY on m1 ----------------
    do_reset();
    m1_valid = 1'b1; m1_addr = 32'h0000_0300;
    step();                                   // BUSY on m1
    check("t5_gnt",    32'(gnt),      32'h2);
    rst = 1'b1; s_ready = 1'b1; s_rdata = 32'h7777_7777;
    #1;
    check("t5_rstcyc_rdy", 32'(m1_ready), 32'h0);
    step();                                   // reset taken
    check("t5_gnt0",   32'(gnt),      32'h0);
    check("t5_svalid", 32'(s_valid),  32'h0);
    check("t5_m1rdy",  32'(m1_ready), 32'h0);
    rst = 1'b0; m0_valid = 1'b1; m0_addr = 32'h0000_0400;
    step();                                   // tie after reset
    check("t5_tie",    32'(gnt),      32'h1);

    // ---------------- 6: m0 drops valid while BUSY ----------------
    do_reset();
    m0_valid = 1'b1; m0_addr = 32'h0000_0500;
    step();                                   // BUSY on m0
    check("t6_gnt",    32'(gnt),      32'h1);
    m0_valid = 1'b0; m1_valid = 1'b1; m1_addr = 32'h0000_0600;
    #1;
    check("t6_svalid", 32'(s_valid),  32'h0);
    check("t6_m0rdy",  32'(m0_ready), 32'h0);
    step();                                   // RELEASE
    check("t6_rel",    32'(gnt),      32'h0);
    check("t6_relsv",  32'(s_valid),  32'h0);
    step();                                   // IDLE
    check("t6_idle",   32'(gnt),      32'h0);
    step();                                   // m1 granted
    check("t6_m1gnt",  32'(gnt),      32'h2);
    check("t6_m1addr", s_addr,        32'h0000_0600);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
